// File: rtl/pe_network_interface_if.sv
// Router-side packet channel of the PE network interface: inbound packets,
// outbound packets and the credit pulses flowing in both directions.
interface pe_network_interface_if #(
    parameter int PKT_W = 36
);
    logic             in_valid;
    logic [PKT_W-1:0] in_data;
    logic             upstream_credit;
    logic             out_valid;
    logic [PKT_W-1:0] out_data;
    logic             downstream_credit;

    // Router side: sends inbound packets, consumes outbound ones.
    modport master (
        output in_valid, in_data, downstream_credit,
        input  upstream_credit, out_valid, out_data
    );

    // Network-interface side.
    modport slave (
        input  in_valid, in_data, downstream_credit,
        output upstream_credit, out_valid, out_data
    );
endinterface

// File: rtl/pe_network_interface.sv
// Network interface between one processing element and its leaf quadtree
// router: decodes inbound packets, serves output-activation reads, merges
// outbound traffic through a credit-controlled output FIFO and returns
// upstream credits through a pending-credit counter.
module pe_network_interface #(
    parameter int INFO_W    = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int PE_IDX_W  = 6,
    parameter int ACT_NO_W  = 6,
    parameter int PE_ADDR_W = 6,
    parameter int DN_DEPTH  = 4,
    parameter int UP_DEPTH  = 4,
    parameter int RQ_DEPTH  = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PE_IDX_W-1:0]           pe_idx,
    pe_network_interface_if.slave         rtr,
    output logic                          pe_status_we,
    output logic [3:0]                    pe_status_addr,
    output logic [DATA_W-1:0]             pe_status_data,
    output logic                          in_act_we,
    output logic [ACT_NO_W-1:0]           in_act_addr,
    output logic [DATA_W-1:0]             in_act_data,
    input  logic [ACT_NO_W-1:0]           out_act_no,
    output logic                          ni_read_rqst,
    output logic [ACT_NO_W-1:0]           ni_read_addr,
    input  logic [DATA_W-1:0]             out_act_read_data,
    output logic                          pe_start_calc,
    output logic                          fin_broadcast,
    output logic                          layer_done,
    input  logic                          act_send_en,
    input  logic [ADDR_W-1:0]             act_send_addr,
    input  logic [DATA_W-1:0]             act_send_data,
    output logic                          act_send_rdy,
    input  logic                          fin_comp,
    output logic                          push_act,
    output logic [PE_ADDR_W+DATA_W-1:0]   act,
    input  logic                          pop_act
);
    localparam int PKT_W     = INFO_W + ADDR_W + DATA_W;
    localparam int RQ_PTR_W  = $clog2(RQ_DEPTH);
    localparam int OUT_PTR_W = $clog2(OUT_DEPTH);
    localparam int CR_W      = $clog2(DN_DEPTH + 1);
    localparam int UPC_W     = $clog2(UP_DEPTH + 1);
    localparam int SUM_W     = $clog2(UP_DEPTH + 4);

    // Router packet info codes.
    localparam logic [INFO_W-1:0] ROUTER_INFO_CONFIG        = 'd0;
    localparam logic [INFO_W-1:0] ROUTER_INFO_CALC          = 'd1;
    localparam logic [INFO_W-1:0] ROUTER_INFO_READ          = 'd2;
    localparam logic [INFO_W-1:0] ROUTER_INFO_BROADCAST     = 'd3;
    localparam logic [INFO_W-1:0] ROUTER_INFO_FIN_BROADCAST = 'd4;
    localparam logic [INFO_W-1:0] ROUTER_INFO_FIN_COMP      = 'd5;

    // ---------------------------------------------------------------- decode
    logic [INFO_W-1:0] in_info;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_pdata;
    logic              unused_addr_bits;

    assign {in_info, in_addr, in_pdata} = rtr.in_data;
    assign unused_addr_bits = ^in_addr[ADDR_W-1:8];

    logic is_config, is_calc, is_read, is_bcast, is_fin_bc, is_fin_comp;
    logic pkt_release;

    assign is_config   = rtr.in_valid && (in_info == ROUTER_INFO_CONFIG);
    assign is_calc     = rtr.in_valid && (in_info == ROUTER_INFO_CALC);
    assign is_read     = rtr.in_valid && (in_info == ROUTER_INFO_READ);
    assign is_bcast    = rtr.in_valid && (in_info == ROUTER_INFO_BROADCAST);
    assign is_fin_bc   = rtr.in_valid && (in_info == ROUTER_INFO_FIN_BROADCAST);
    assign is_fin_comp = rtr.in_valid && (in_info == ROUTER_INFO_FIN_COMP);

    // Broadcasts held in the activation queue return their credit on pop_act.
    assign push_act    = is_bcast && (out_act_no != '0);
    assign act         = {in_addr[PE_ADDR_W-1:0], in_pdata};
    assign pkt_release = is_config || is_calc || is_fin_bc || is_fin_comp ||
                         (is_bcast && (out_act_no == '0));

    // Register configuration writes and control pulses one cycle after the packet.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_status_we   <= 1'b0;
            pe_status_addr <= '0;
            pe_status_data <= '0;
            in_act_we      <= 1'b0;
            in_act_addr    <= '0;
            in_act_data    <= '0;
            pe_start_calc  <= 1'b0;
            fin_broadcast  <= 1'b0;
            layer_done     <= 1'b0;
        end else begin
            pe_status_we  <= is_config && !in_addr[7];
            in_act_we     <= is_config && in_addr[7];
            pe_start_calc <= is_calc;
            fin_broadcast <= is_fin_bc;
            layer_done    <= is_fin_comp;
            if (is_config && !in_addr[7]) begin
                pe_status_addr <= in_addr[3:0];
                pe_status_data <= in_pdata;
            end
            if (is_config && in_addr[7]) begin
                in_act_addr <= in_addr[ACT_NO_W:1];
                in_act_data <= in_pdata;
            end
        end
    end

    // ------------------------------------------------------ read-request FIFO
    logic [ACT_NO_W-1:0] rq_mem [RQ_DEPTH];
    logic [RQ_PTR_W:0]   rq_wr_ptr, rq_rd_ptr;
    logic                rq_empty, rq_full, rq_push;

    assign rq_empty = (rq_wr_ptr == rq_rd_ptr);
    assign rq_full  = (rq_wr_ptr[RQ_PTR_W] != rq_rd_ptr[RQ_PTR_W]) &&
                      (rq_wr_ptr[RQ_PTR_W-1:0] == rq_rd_ptr[RQ_PTR_W-1:0]);
    assign rq_push  = is_read && !rq_full;

    // Store read addresses.
    // NOTE: FIFO storage is not reset; the pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (rq_push) rq_mem[rq_wr_ptr[RQ_PTR_W-1:0]] <= in_addr[ACT_NO_W-1:0];
    end

    // ------------------------------------------------------- output arbitration
    logic [OUT_PTR_W:0] out_wr_ptr, out_rd_ptr, out_count;
    logic               out_full, out_empty;
    logic               fin_pending;
    logic               act_grant, fin_grant, rd_grant, enq;
    logic [PKT_W-1:0]   enq_pkt;
    logic [INFO_W-1:0]  act_info;

    assign out_count    = out_wr_ptr - out_rd_ptr;
    assign out_full     = (out_count == (OUT_PTR_W + 1)'(OUT_DEPTH));
    assign out_empty    = (out_count == '0);
    assign act_send_rdy = !out_full;
    assign act_info     = act_send_addr[ADDR_W-1] ? ROUTER_INFO_FIN_BROADCAST
                                                  : ROUTER_INFO_BROADCAST;
    assign ni_read_rqst = rd_grant;
    assign ni_read_addr = rq_empty ? '0 : rq_mem[rq_rd_ptr[RQ_PTR_W-1:0]];

    // Fixed priority: activation send, then finish-computation, then read response.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        act_grant = 1'b0;
        fin_grant = 1'b0;
        rd_grant  = 1'b0;
        enq_pkt   = '0;
        if (!out_full) begin
            if (act_send_en) begin
                act_grant = 1'b1;
                enq_pkt   = {act_info, act_send_addr, act_send_data};
            end else if (fin_pending) begin
                fin_grant = 1'b1;
                enq_pkt   = {ROUTER_INFO_FIN_COMP, {ADDR_W{1'b0}},
                             {(DATA_W - PE_IDX_W){1'b0}}, pe_idx};
            end else if (!rq_empty) begin
                rd_grant  = 1'b1;
                enq_pkt   = {ROUTER_INFO_READ,
                             {(ADDR_W - ACT_NO_W - PE_IDX_W){1'b0}}, ni_read_addr, pe_idx,
                             out_act_read_data};
            end
        end
    end

    assign enq = act_grant || fin_grant || rd_grant;

    // ------------------------------------------------------------ output FIFO
    logic [PKT_W-1:0] out_mem [OUT_DEPTH];
    logic [CR_W-1:0]  credit_cnt;
    logic             send;
    logic             out_valid_q;
    logic [PKT_W-1:0] out_data_q;

    assign send         = !out_empty && (credit_cnt != '0);
    assign rtr.out_valid = out_valid_q;
    assign rtr.out_data  = out_data_q;

    // Store granted outbound packets.
    always_ff @(posedge clk) begin
        if (enq) out_mem[out_wr_ptr[OUT_PTR_W-1:0]] <= enq_pkt;
    end

    // FIFO pointers, finish flag, outbound register and downstream credits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq_wr_ptr   <= '0;
            rq_rd_ptr   <= '0;
            out_wr_ptr  <= '0;
            out_rd_ptr  <= '0;
            fin_pending <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            credit_cnt  <= CR_W'(DN_DEPTH);
        end else begin
            if (rq_push)  rq_wr_ptr  <= rq_wr_ptr + 1'b1;
            if (rd_grant) rq_rd_ptr  <= rq_rd_ptr + 1'b1;
            if (enq)      out_wr_ptr <= out_wr_ptr + 1'b1;
            if (send)     out_rd_ptr <= out_rd_ptr + 1'b1;
            fin_pending <= (fin_pending && !fin_grant) || fin_comp;
            out_valid_q <= send;
            if (send) out_data_q <= out_mem[out_rd_ptr[OUT_PTR_W-1:0]];
            case ({send, rtr.downstream_credit})
                2'b10:   credit_cnt <= credit_cnt - 1'b1;
                2'b01:   credit_cnt <= credit_cnt + 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // --------------------------------------------------- upstream credit return
    logic [UPC_W-1:0] pend_cnt;
    logic [SUM_W-1:0] pend_sum, pend_next;
    logic             credit_issue, pend_ovf, upstream_credit_q;

    assign rtr.upstream_credit = upstream_credit_q;

    // Add this cycle's release events, then spend one pulse if anything is owed.
    always_comb begin
        pend_sum     = SUM_W'(pend_cnt) + SUM_W'(pkt_release) + SUM_W'(rd_grant) +
                       SUM_W'(pop_act);
        credit_issue = (pend_sum != '0);
        pend_next    = pend_sum - SUM_W'(credit_issue);
        pend_ovf     = (pend_next > SUM_W'(UP_DEPTH));
    end

    // Pending-credit counter and registered credit pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt          <= '0;
            upstream_credit_q <= 1'b0;
        end else begin
            pend_cnt          <= pend_ovf ? UPC_W'(UP_DEPTH) : UPC_W'(pend_next);
            upstream_credit_q <= credit_issue;
        end
    end

`ifndef SYNTHESIS
    // Report protocol violations in simulation; hardware drops or saturates.
    always_ff @(posedge clk) begin
        if (!rst && act_send_en && !act_send_rdy)
            $display("pe_network_interface error: act_send_en while act_send_rdy=0, request dropped");
        if (!rst && pend_ovf)
            $display("pe_network_interface error: pending upstream credits exceed UP_DEPTH, saturated");
    end
`endif

endmodule

// File: tb/tb_pe_network_interface.sv
// Directed self-checking bench for pe_network_interface.
module tb_pe_network_interface;
    localparam int INFO_W = 4, ADDR_W = 16, DATA_W = 16;
    localparam int PKT_W  = INFO_W + ADDR_W + DATA_W;

    localparam logic [3:0] RI_CONFIG = 4'd0, RI_CALC = 4'd1, RI_READ = 4'd2,
                           RI_BCAST  = 4'd3, RI_FIN_BC = 4'd4, RI_FIN_COMP = 4'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pe_idx;
    logic        pe_status_we;
    logic [3:0]  pe_status_addr;
    logic [15:0] pe_status_data;
    logic        in_act_we;
    logic [5:0]  in_act_addr;
    logic [15:0] in_act_data;
    logic [5:0]  out_act_no;
    logic        ni_read_rqst;
    logic [5:0]  ni_read_addr;
    logic [15:0] out_act_read_data;
    logic        pe_start_calc, fin_broadcast, layer_done;
    logic        act_send_en;
    logic [15:0] act_send_addr, act_send_data;
    logic        act_send_rdy;
    logic        fin_comp;
    logic        push_act;
    logic [21:0] act;
    logic        pop_act;

    int n_checks = 0;
    int n_fail   = 0;
    bit auto_credit;
    int n_out;

    pe_network_interface_if #(.PKT_W(PKT_W)) nif ();

    pe_network_interface dut (
        .clk(clk), .rst(rst), .pe_idx(pe_idx), .rtr(nif),
        .pe_status_we(pe_status_we), .pe_status_addr(pe_status_addr),
        .pe_status_data(pe_status_data),
        .in_act_we(in_act_we), .in_act_addr(in_act_addr), .in_act_data(in_act_data),
        .out_act_no(out_act_no), .ni_read_rqst(ni_read_rqst), .ni_read_addr(ni_read_addr),
        .out_act_read_data(out_act_read_data),
        .pe_start_calc(pe_start_calc), .fin_broadcast(fin_broadcast), .layer_done(layer_done),
        .act_send_en(act_send_en), .act_send_addr(act_send_addr),
        .act_send_data(act_send_data), .act_send_rdy(act_send_rdy),
        .fin_comp(fin_comp), .push_act(push_act), .act(act), .pop_act(pop_act)
    );

    always #5 clk = ~clk;

    // Output activation register file: entry n holds n*10.
    assign out_act_read_data = 16'(ni_read_addr) * 16'd10;

    function automatic logic [PKT_W-1:0] pkt(input logic [3:0] info, input logic [15:0] a,
                                             input logic [15:0] d);
        return {info, a, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; optionally act as a
    // downstream router that returns one credit per packet received.
    task automatic tick();
        @(posedge clk);
        #1;
        nif.downstream_credit = auto_credit & nif.out_valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_pkt(input logic [PKT_W-1:0] p);
        nif.in_valid = 1'b1;
        nif.in_data  = p;
    endtask

    task automatic expect_out(input string tag, input logic [PKT_W-1:0] exp, input int budget);
        int n = 0;
        while (!nif.out_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(nif.out_valid), 64'(1'b1));
        check(tag, 64'(nif.out_data), 64'(exp));
    endtask

    initial begin
        rst = 1'b1; pe_idx = 6'd5; out_act_no = '0; pop_act = 1'b0;
        act_send_en = 1'b0; act_send_addr = '0; act_send_data = '0; fin_comp = 1'b0;
        nif.in_valid = 1'b0; nif.in_data = '0; nif.downstream_credit = 1'b0;
        auto_credit = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_status_we", 64'(pe_status_we), 64'(0));
        check("rst_up_credit", 64'(nif.upstream_credit), 64'(0));
        check("rst_out_valid", 64'(nif.out_valid), 64'(0));
        check("rst_send_rdy", 64'(act_send_rdy), 64'(1));
        check("rst_read_rqst", 64'(ni_read_rqst), 64'(0));

        // CONFIG status write
        tick(); send_pkt(pkt(RI_CONFIG, 16'h0003, 16'h1234));
        tick(); nif.in_valid = 1'b0;
        check("cfg_status_we", 64'(pe_status_we), 64'(1));
        check("cfg_status_addr", 64'(pe_status_addr), 64'(3));
        check("cfg_status_data", 64'(pe_status_data), 64'h1234);
        check("cfg_credit", 64'(nif.upstream_credit), 64'(1));
        tick();
        check("cfg_status_we_off", 64'(pe_status_we), 64'(0));
        check("cfg_credit_single", 64'(nif.upstream_credit), 64'(0));

        // CONFIG input-activation write: addr 0x85 -> index 2
        send_pkt(pkt(RI_CONFIG, 16'h0085, 16'hBEEF));
        tick(); nif.in_valid = 1'b0;
        check("inact_we", 64'(in_act_we), 64'(1));
        check("inact_addr", 64'(in_act_addr), 64'(2));
        check("inact_data", 64'(in_act_data), 64'hBEEF);
        check("inact_no_status", 64'(pe_status_we), 64'(0));

        // CALC then inbound FIN_COMP control pulses
        tick(); send_pkt(pkt(RI_CALC, 16'h0, 16'h0));
        tick(); send_pkt(pkt(RI_FIN_COMP, 16'h0, 16'h0));
        check("calc_pulse", 64'(pe_start_calc), 64'(1));
        tick(); nif.in_valid = 1'b0;
        check("layer_done_pulse", 64'(layer_done), 64'(1));
        check("calc_pulse_off", 64'(pe_start_calc), 64'(0));
        idle(4);

        // Three release events in one cycle: read dequeue, FIN_BROADCAST, pop_act
        send_pkt(pkt(RI_READ, 16'h0007, 16'h0));
        tick();
        send_pkt(pkt(RI_FIN_BC, 16'h0, 16'h0)); pop_act = 1'b1; #1;
        check("tri_read_rqst", 64'(ni_read_rqst), 64'(1));
        check("tri_read_addr", 64'(ni_read_addr), 64'(7));
        tick(); nif.in_valid = 1'b0; pop_act = 1'b0;
        check("tri_fin_bc", 64'(fin_broadcast), 64'(1));
        check("tri_credit1", 64'(nif.upstream_credit), 64'(1));
        tick();
        check("tri_credit2", 64'(nif.upstream_credit), 64'(1));
        check("tri_rsp_valid", 64'(nif.out_valid), 64'(1));
        check("tri_rsp", 64'(nif.out_data), 64'(pkt(RI_READ, 16'h01C5, 16'd70)));
        tick();
        check("tri_credit3", 64'(nif.upstream_credit), 64'(1));
        tick();
        check("tri_credit_done", 64'(nif.upstream_credit), 64'(0));
        idle(3);

        // Three READs in a row: responses in order
        send_pkt(pkt(RI_READ, 16'h0001, 16'h0));
        tick(); send_pkt(pkt(RI_READ, 16'h0002, 16'h0));
        tick(); send_pkt(pkt(RI_READ, 16'h0003, 16'h0));
        tick(); nif.in_valid = 1'b0;
        expect_out("rd1", pkt(RI_READ, 16'h0045, 16'd10), 6);
        tick();
        expect_out("rd2", pkt(RI_READ, 16'h0085, 16'd20), 1);
        tick();
        expect_out("rd3", pkt(RI_READ, 16'h00C5, 16'd30), 1);
        idle(6);

        // BROADCAST without allocated outputs: credit returned at once
        send_pkt(pkt(RI_BCAST, 16'h0025, 16'h7777)); #1;
        check("bc0_no_push", 64'(push_act), 64'(0));
        tick(); nif.in_valid = 1'b0;
        check("bc0_credit", 64'(nif.upstream_credit), 64'(1));
        tick();

        // BROADCAST into the activation queue: credit waits for pop_act
        out_act_no = 6'd3;
        send_pkt(pkt(RI_BCAST, 16'h0025, 16'h7777)); #1;
        check("bc3_push", 64'(push_act), 64'(1));
        check("bc3_act", 64'(act), 64'h25_7777);
        tick(); nif.in_valid = 1'b0;
        check("bc3_no_credit", 64'(nif.upstream_credit), 64'(0));
        tick();
        check("bc3_no_credit2", 64'(nif.upstream_credit), 64'(0));
        pop_act = 1'b1;
        tick(); pop_act = 1'b0;
        check("bc3_pop_credit", 64'(nif.upstream_credit), 64'(1));
        idle(3);

        // act_send and fin_comp together: BROADCAST at t+2, then FIN_COMP
        act_send_en = 1'b1; act_send_addr = 16'h0012; act_send_data = 16'hABCD;
        fin_comp = 1'b1; #1;
        check("as_rdy", 64'(act_send_rdy), 64'(1));
        tick(); act_send_en = 1'b0; fin_comp = 1'b0;
        check("as_latency_t1", 64'(nif.out_valid), 64'(0));
        tick();
        check("as_latency_t2", 64'(nif.out_valid), 64'(1));
        check("as_bcast", 64'(nif.out_data), 64'(pkt(RI_BCAST, 16'h0012, 16'hABCD)));
        tick();
        expect_out("as_fin", pkt(RI_FIN_COMP, 16'h0000, 16'h0005), 3);
        tick();

        // act_send with the address MSB set goes out as FIN_BROADCAST
        act_send_en = 1'b1; act_send_addr = 16'h8001; act_send_data = 16'h0042;
        tick(); act_send_en = 1'b0;
        expect_out("as_fin_bc", pkt(RI_FIN_BC, 16'h8001, 16'h0042), 4);
        idle(4);

        // Downstream credits: reset restores DN_DEPTH, bench returns none
        auto_credit = 1'b0; nif.downstream_credit = 1'b0;
        rst = 1'b1; idle(2); rst = 1'b0;
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            act_send_en = 1'b1; act_send_addr = 16'(i); act_send_data = 16'h0100 + 16'(i);
            tick();
            if (nif.out_valid) n_out++;
        end
        act_send_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (nif.out_valid) n_out++;
        end
        check("dn_sent_4", 64'(n_out), 64'(4));
        check("dn_rdy_full", 64'(act_send_rdy), 64'(0));
        nif.downstream_credit = 1'b1;
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (nif.out_valid) n_out++;
        end
        check("dn_one_more", 64'(n_out), 64'(1));
        check("dn_rdy_again", 64'(act_send_rdy), 64'(1));

        // Mid-operation reset discards queued packets
        rst = 1'b1; tick(); rst = 1'b0;
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (nif.out_valid) n_out++;
        end
        check("rst_discard", 64'(n_out), 64'(0));
        check("rst_rdy", 64'(act_send_rdy), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
